// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// sync_fifo_pkg -- read-mode selector shared by the programmable FIFO.
// Rev 1.0
package sync_fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// sync_fifo_ram -- simple dual-port storage, one write port and a registered read port.
// Rev 1.0
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/sync_fifo_prog.sv
`default_nettype none
// sync_fifo_prog -- single-clock FIFO, standard or FWFT read, programmable almost flags.
// Rev 1.0
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         DEPTH      = 16,
  parameter fifo_mode_e MODE       = FIFO_STD,
  localparam int        CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  input  logic [CW-1:0]         i_afull_thresh,
  input  logic [CW-1:0]         i_aempty_thresh,
  output logic [CW-1:0]         o_level,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of two >= 2");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         level;
  logic                  wr_acc, rd_acc, ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_q;

  assign o_full         = (level == CW'(DEPTH));
  assign o_empty        = (level == '0);
  assign o_level        = level;
  assign o_almost_full  = (level >= i_afull_thresh);
  assign o_almost_empty = (level <= i_aempty_thresh);

  assign wr_acc = i_wr_en & ~o_full  & ~i_clr;
  assign rd_acc = i_rd_en & ~o_empty & ~i_clr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc)      level <= level + CW'(1);
      else if (rd_acc && !wr_acc) level <= level - CW'(1);
      if (ram_we) wr_ptr <= wr_ptr + AW'(1);
      if (ram_re) rd_ptr <= rd_ptr + AW'(1);
      if (i_wr_en && o_full)  o_overflow  <= 1'b1;
      if (i_rd_en && o_empty) o_underflow <= 1'b1;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (i_wr_data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic valid_q;

    assign ram_we     = wr_acc;
    assign ram_re     = rd_acc;
    assign o_rd_data  = ram_q;
    assign o_rd_valid = valid_q;

    always_ff @(posedge clk) begin
      if (rst || i_clr) valid_q <= 1'b0;
      else              valid_q <= rd_acc;
    end
  end else begin : g_fwft
    // Head word lives either in the bypass register or in the RAM read register;
    // the RAM only ever holds the words behind the head.
    logic                  bypass, from_ram;
    logic [DATA_WIDTH-1:0] byp_data;

    assign bypass     = wr_acc & (o_empty | (rd_acc & (level == CW'(1))));
    assign ram_we     = wr_acc & ~bypass;
    assign ram_re     = rd_acc & (level > CW'(1));
    assign o_rd_valid = ~o_empty;
    assign o_rd_data  = from_ram ? ram_q : byp_data;

    always_ff @(posedge clk) begin
      if (rst)         from_ram <= 1'b0;
      else if (bypass) from_ram <= 1'b0;
      else if (ram_re) from_ram <= 1'b1;
    end

    always_ff @(posedge clk) begin
      if (bypass) byp_data <= i_wr_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// tb_sync_fifo_prog -- scoreboard bench driving a STD and a FWFT instance with shared stimulus.
// Rev 1.0
module tb_sync_fifo_prog;
  import sync_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] afull_th, aempty_th;

  logic          full_s, afull_s, valid_s, empty_s, aempty_s, ovf_s, udf_s;
  logic          full_f, afull_f, valid_f, empty_f, aempty_f, ovf_f, udf_f;
  logic [DW-1:0] data_s, data_f;
  logic [CW-1:0] level_s, level_f;

  int            n_chk = 0;
  int            n_fail = 0;
  int            n_pulse_s = 0;
  int            n_exp_pulse = 0;
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] exp_s, exp_f;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_STD)) dut_std (
    .clk(clk), .rst(rst), .i_clr(clr), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full_s), .o_almost_full(afull_s), .i_rd_en(rd_en), .o_rd_data(data_s),
    .o_rd_valid(valid_s), .o_empty(empty_s), .o_almost_empty(aempty_s),
    .i_afull_thresh(afull_th), .i_aempty_thresh(aempty_th), .o_level(level_s),
    .o_overflow(ovf_s), .o_underflow(udf_s)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) dut_fwft (
    .clk(clk), .rst(rst), .i_clr(clr), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full_f), .o_almost_full(afull_f), .i_rd_en(rd_en), .o_rd_data(data_f),
    .o_rd_valid(valid_f), .o_empty(empty_f), .o_almost_empty(aempty_f),
    .i_afull_thresh(afull_th), .i_aempty_thresh(aempty_th), .o_level(level_f),
    .o_overflow(ovf_f), .o_underflow(udf_f)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_both(input string name, input logic [31:0] a_s, input logic [31:0] a_f,
                          input logic [31:0] exp);
    chk({"std ", name}, a_s, exp);
    chk({"fwft ", name}, a_f, exp);
  endtask

  task automatic chk_state(input string tag, input int lvl, input bit full, input bit empty,
                           input bit ovf, input bit udf);
    chk_both({tag, " level"}, level_s, level_f, lvl);
    chk_both({tag, " full"}, full_s, full_f, full);
    chk_both({tag, " empty"}, empty_s, empty_f, empty);
    chk_both({tag, " overflow"}, ovf_s, ovf_f, ovf);
    chk_both({tag, " underflow"}, udf_s, udf_f, udf);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: STD delivers on each valid pulse, FWFT delivers when a pop is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_s) begin
        n_pulse_s++;
        if (q_s.size() == 0) chk("std unexpected read data", data_s, 32'hDEAD);
        else begin
          exp_s = q_s.pop_front();
          chk("std read data", data_s, exp_s);
        end
      end
      if (rd_en && valid_f) begin
        if (q_f.size() == 0) chk("fwft unexpected pop data", data_f, 32'hDEAD);
        else begin
          exp_f = q_f.pop_front();
          chk("fwft pop data", data_f, exp_f);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    afull_th = CW'(6); aempty_th = CW'(2);
    repeat (2) tick();
    rst = 1'b0;
    chk_state("reset", 0, 0, 1, 0, 0);
    chk_both("reset valid", valid_s, valid_f, 0);
    chk_both("reset almost_empty", aempty_s, aempty_f, 1);
    chk_both("reset almost_full", afull_s, afull_f, 0);

    // Fill 0x01..0x08 and follow the almost flags with afull=6, aempty=2.
    for (int i = 1; i <= DEPTH; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      q_s.push_back(DW'(i)); q_f.push_back(DW'(i));
      tick();
      chk_both("fill level", level_s, level_f, i);
      chk_both("fill almost_empty", aempty_s, aempty_f, (i <= 2));
      chk_both("fill almost_full", afull_s, afull_f, (i >= 6));
    end
    wr_en = 1'b0;
    chk_both("full flag", full_s, full_f, 1);
    aempty_th = CW'(8); #1;
    chk_both("aempty thresh=DEPTH", aempty_s, aempty_f, 1);
    aempty_th = CW'(7); #1;
    chk_both("aempty thresh=7 at full", aempty_s, aempty_f, 0);
    aempty_th = CW'(2);

    wr_en = 1'b1; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk_state("overflow", 8, 1, 0, 1, 0);

    // Full with simultaneous write and read: read wins, write dropped.
    wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1; n_exp_pulse++;
    tick();
    wr_en = 1'b0;
    chk_state("full wr+rd", 7, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      n_exp_pulse++;
      tick();
    end
    rd_en = 1'b0;
    tick();
    chk_state("drained", 0, 0, 1, 1, 0);

    clr = 1'b1; tick(); clr = 1'b0;
    chk_state("clear1", 0, 0, 1, 0, 0);

    // Single write into empty FIFO: only FWFT shows the head word.
    wr_en = 1'b1; wr_data = 8'hA5;
    q_s.push_back(8'hA5); q_f.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    chk("std valid after write", valid_s, 0);
    chk("fwft valid after write", valid_f, 1);
    chk("fwft head data", data_f, 8'hA5);
    rd_en = 1'b1; n_exp_pulse++;
    tick();
    rd_en = 1'b0;
    chk_both("empty after pop", empty_s, empty_f, 1);
    tick();

    // Empty with simultaneous write and read: write accepted, read dropped.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_state("empty wr+rd", 1, 0, 0, 0, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk_state("clear2", 0, 0, 1, 0, 0);
    chk_both("clear2 valid", valid_s, valid_f, 0);

    afull_th = CW'(0); #1;
    chk_both("afull thresh=0", afull_s, afull_f, 1);
    afull_th = CW'(6); #1;
    chk_both("afull thresh=6 at empty", afull_s, afull_f, 0);

    // Pointer wrap with interleaved write/read pairs.
    wr_en = 1'b1; wr_data = 8'h40;
    q_s.push_back(8'h40); q_f.push_back(8'h40);
    tick();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(8'h41 + i);
      q_s.push_back(DW'(8'h41 + i)); q_f.push_back(DW'(8'h41 + i));
      n_exp_pulse++;
      tick();
      chk_both("wrap level", level_s, level_f, 1);
    end
    wr_en = 1'b0; n_exp_pulse++;
    tick();
    rd_en = 1'b0;
    repeat (2) tick();
    chk_state("final", 0, 0, 1, 0, 0);
    chk("std scoreboard drained", q_s.size(), 0);
    chk("fwft scoreboard drained", q_f.size(), 0);
    chk("std valid pulse count", n_pulse_s, n_exp_pulse);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
